// File: rtl/window_buffer.sv
// Raster-to-window converter: WINDOW_SIZE-1 chained line buffers feed a WINDOW_SIZE x WINDOW_SIZE
// register window; only fully populated windows are emitted. Optional sof_i under WINDOW_BUF_SOF_EN.
module window_buffer #(
    parameter int PIX_DATA_W    = 12,
    parameter int WINDOW_SIZE   = 7,
    parameter int FRAME_W       = 640,
    parameter int FRAME_H       = 480,
    parameter int INPUTS_AMOUNT = WINDOW_SIZE**2
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
`ifdef WINDOW_BUF_SOF_EN
    input  logic                                     sof_i,
`endif
    input  logic                                     data_valid_i,
    input  logic [PIX_DATA_W-1:0]                    data_i,
    output logic                                     data_valid_o,
    output logic [INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] data_o
);

    localparam int WS = WINDOW_SIZE;
    localparam int CW = $clog2(FRAME_W);
    localparam int RW = $clog2(FRAME_H);
    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(WS - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(WS - 1);

    logic sof;
`ifdef WINDOW_BUF_SOF_EN
    assign sof = sof_i;
`else
    assign sof = 1'b0;
`endif

    logic [CW-1:0] col_q, col_d, col_eff;
    logic [RW-1:0] row_q, row_d, row_eff;
    logic [WS-1:0][WS-1:0][PIX_DATA_W-1:0] win_q, win_d;
    logic [INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] dat_q, dat_d;
    logic vld_q, vld_d;

    // Line buffer k holds the line k+1 rows above the current one; contents are never reset.
    logic [PIX_DATA_W-1:0] lb_mem [WS-1][FRAME_W];
    logic [WS-2:0][PIX_DATA_W-1:0] lb_rd, lb_wr;
    logic [WS-1:0][PIX_DATA_W-1:0] new_col;

    always_comb begin
        col_eff = sof ? '0 : col_q;
        row_eff = sof ? '0 : row_q;
        for (int k = 0; k < WS-1; k++) begin
            lb_rd[k] = lb_mem[k][col_eff];
            lb_wr[k] = (k == 0) ? data_i : lb_rd[(k == 0) ? 0 : k-1];
        end
        for (int r = 0; r < WS-1; r++)
            new_col[r] = lb_rd[WS-2-r];
        new_col[WS-1] = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (data_valid_i)
            for (int k = 0; k < WS-1; k++)
                lb_mem[k][col_eff] <= lb_wr[k];
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        win_d = win_q;
        vld_d = 1'b0;
        dat_d = dat_q;
        if (data_valid_i) begin
            for (int r = 0; r < WS; r++) begin
                for (int c = 0; c < WS-1; c++)
                    win_d[r][c] = win_q[r][c+1];
                win_d[r][WS-1] = new_col[r];
            end
            if (col_eff == COL_LAST) begin
                col_d = '0;
                row_d = (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
            end else begin
                col_d = col_eff + CW'(1);
                row_d = row_eff;
            end
            // Qualification keeps windows inside one line/frame and away from stale buffer data.
            if (col_eff >= COL_MIN && row_eff >= ROW_MIN) begin
                vld_d = 1'b1;
                dat_d = win_d;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign data_valid_o = vld_q;
    assign data_o       = dat_q;

endmodule

// File: tb/tb_window_buffer.sv
// Scoreboard bench for window_buffer on an 8x6 frame with 3x3 windows; reference model keeps a
// frame image and builds expected windows directly from pixel positions.
module tb_window_buffer;

    localparam int PW  = 12;
    localparam int WS  = 3;
    localparam int FW  = 8;
    localparam int FH  = 6;
    localparam int NI  = WS*WS;
    localparam int WPF = (FW-WS+1)*(FH-WS+1);

    typedef logic [NI-1:0][PW-1:0] win_t;
    typedef struct {
        int   cyc;
        win_t win;
    } exp_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          sof_i = 1'b0;
    logic          data_valid_i = 1'b0;
    logic [PW-1:0] data_i = '0;
    logic          data_valid_o;
    win_t          data_o;

    window_buffer #(
        .PIX_DATA_W (PW),
        .WINDOW_SIZE(WS),
        .FRAME_W    (FW),
        .FRAME_H    (FH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
`ifdef WINDOW_BUF_SOF_EN
        .sof_i       (sof_i),
`endif
        .data_valid_i(data_valid_i),
        .data_i      (data_i),
        .data_valid_o(data_valid_o),
        .data_o      (data_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    exp_t          sb[$];
    int            n_chk = 0;
    int            n_fail = 0;
    int            win_cnt = 0;
    int            mr = 0;
    int            mc = 0;
    logic [PW-1:0] img [FH][FW];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: store pixel at its raster position, emit the window ending there if fully inside the frame.
    task automatic send(input logic [PW-1:0] v, input int gap, input bit sof);
        exp_t e;
        data_valid_i = 1'b1;
        data_i       = v;
        sof_i        = sof;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = v;
        if (mr >= WS-1 && mc >= WS-1) begin
            e.cyc = cyc + 1;
            for (int r = 0; r < WS; r++)
                for (int c = 0; c < WS; c++)
                    e.win[r*WS+c] = img[mr-WS+1+r][mc-WS+1+c];
            sb.push_back(e);
        end
        mc++;
        if (mc == FW) begin
            mc = 0;
            mr = (mr == FH-1) ? 0 : mr + 1;
        end
        @(posedge clk_i); #1;
        sof_i = 1'b0;
        if (gap > 0) begin
            data_valid_i = 1'b0;
            repeat (gap) begin @(posedge clk_i); #1; end
        end
    endtask

    task automatic frame(input int gap_max, input bit rnd, input bit sof);
        win_t          first;
        logic [PW-1:0] v;
        int            g;
        for (int r = 0; r < WS; r++)
            for (int c = 0; c < WS; c++)
                first[r*WS+c] = PW'(r*16 + c);
        for (int idx = 0; idx < FW*FH; idx++) begin
            v = rnd ? PW'($urandom_range(0, 4095)) : PW'((idx/FW)*16 + idx%FW);
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            send(v, g, sof && idx == 0);
            if (g == 0 && idx == 17) chk("no_valid_before_19th", data_valid_o, 0);
            if (g == 0 && idx == 18) chk("valid_after_19th", data_valid_o, 1);
            if (!rnd && idx == 18) chk("first_window", data_o, first);
            if (!rnd && idx == FW*FH-1) chk("last_window_tap8", data_o[NI-1], 12'h57);
        end
    endtask

    task automatic drain();
        data_valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: pops one expected window per output valid; data_o must hold while valid is low.
    initial begin
        exp_t e;
        bit   prev_rst = 1'b1;
        win_t last = '0;
        forever begin
            @(negedge clk_i);
            if (data_valid_o) begin
                win_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("window_cycle", cyc, e.cyc);
                    chk("window_data", data_o, e.win);
                end
            end else if (!rst_i && !prev_rst) begin
                chk("hold_during_gap", data_o, last);
            end
            last     = data_o;
            prev_rst = rst_i;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset_valid", data_valid_o, 0);
        chk("reset_data", data_o, 0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        c0 = win_cnt;
        frame(0, 1'b0, 1'b0);
        frame(0, 1'b0, 1'b0);
        drain();
        chk("two_frame_count", win_cnt - c0, 2*WPF);

        c0 = win_cnt;
        frame(5, 1'b0, 1'b0);
        drain();
        chk("gap_frame_count", win_cnt - c0, WPF);

        c0 = win_cnt;
        frame(3, 1'b1, 1'b0);
        drain();
        chk("random_frame_count", win_cnt - c0, WPF);

        // 30th pixel is row 3 col 5, so a window is on the output when reset hits.
        for (int idx = 0; idx < 30; idx++)
            send(PW'((idx/FW)*16 + idx%FW), 0, 1'b0);
        data_valid_i = 1'b0;
        chk("valid_before_reset", data_valid_o, 1);
        rst_i = 1'b1;
        #1;
        chk("async_reset_valid", data_valid_o, 0);
        chk("async_reset_data", data_o, 0);
        sb.delete();
        mr = 0;
        mc = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        c0 = win_cnt;
        frame(0, 1'b0, 1'b0);
        drain();
        chk("post_reset_count", win_cnt - c0, WPF);

`ifdef WINDOW_BUF_SOF_EN
        for (int idx = 0; idx < 12; idx++)
            send(PW'($urandom_range(0, 4095)), 0, 1'b0);
        c0 = win_cnt;
        frame(0, 1'b0, 1'b1);
        drain();
        chk("sof_frame_count", win_cnt - c0, WPF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
